// File: rtl/impulse_sequencer_if.sv
// Purpose : signal bundle between board buttons/control and impulse_sequencer.
// Latency : none (wires only).
// Backpressure : none; `impulse` is consumed by the counter unconditionally.
// Ports   : req_raw/req_en/clr_ovf driven by the master (board side);
//           impulse/grant_id/busy/overflow driven by the slave (sequencer).
interface impulse_sequencer_if #(
  parameter int N_REQ = 4
) ();
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0] req_raw;
  logic [N_REQ-1:0] req_en;
  logic             clr_ovf;
  logic             impulse;
  logic [GW-1:0]    grant_id;
  logic             busy;
  logic [N_REQ-1:0] overflow;

  modport master (
    output req_raw, req_en, clr_ovf,
    input  impulse, grant_id, busy, overflow
  );

  modport slave (
    input  req_raw, req_en, clr_ovf,
    output impulse, grant_id, busy, overflow
  );
endinterface

// File: rtl/impulse_sequencer.sv
// Purpose : debounce N_REQ buttons, count pending presses, issue round-robin
//           single-cycle increment pulses spaced by MIN_GAP idle cycles.
// Latency : press first sampled at edge E0 -> impulse in cycle after E0+2+DEBOUNCE_CYCLES.
// Backpressure : none downstream; excess presses saturate pend and set overflow.
// Ports   : clk, nrst (sync, active-low); bus.slave carries req_raw, req_en,
//           clr_ovf in and impulse, grant_id, busy, overflow out.
module impulse_sequencer #(
  parameter int N_REQ           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_GAP         = 4,
  parameter int PEND_W          = 3
) (
  input logic                clk,
  input logic                nrst,
  impulse_sequencer_if.slave bus
);

  localparam int GW    = $clog2(N_REQ);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int GAP_W = $clog2(MIN_GAP + 1);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [GW-1:0]     PTR_RST  = GW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } state_t;

  // input conditioning
  logic [N_REQ-1:0]  sync0;
  logic [N_REQ-1:0]  sync1;
  logic [N_REQ-1:0]  stable;
  logic [DB_W-1:0]   db_cnt [N_REQ];
  logic [N_REQ-1:0]  rise;

  // pending bookkeeping
  logic [PEND_W-1:0] pend [N_REQ];
  logic [N_REQ-1:0]  pend_nz;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  inc;
  logic [N_REQ-1:0]  dec;
  logic [N_REQ-1:0]  new_ovf;
  logic [N_REQ-1:0]  ovf;

  // arbitration / sequencing
  state_t            state;
  state_t            state_nxt;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     win_q;
  logic [GW-1:0]     winner;
  logic              any_elig;
  logic [GAP_W-1:0]  gap_cnt;
  logic              impulse_q;
  logic [GW-1:0]     grant_q;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= bus.req_raw;
      sync1 <= sync0;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer: count consecutive samples that disagree with the accepted level;
  // the DEBOUNCE_CYCLES-th disagreeing sample flips the level.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      stable <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (sync1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          stable[i] <= ~stable[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // A rising flip is recognised combinationally so the pending count moves on
  // the same edge that sets stable[i].
  always_comb begin
    rise     = '0;
    inc      = '0;
    dec      = '0;
    new_ovf  = '0;
    pend_nz  = '0;
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rise[i]     = sync1[i] & ~stable[i] & (db_cnt[i] == DB_LAST);
      inc[i]      = rise[i] & bus.req_en[i];
      dec[i]      = (state == FIRE) && (win_q == GW'(i));
      // An increment that coincides with a grant is not lost, so no overflow.
      new_ovf[i]  = inc[i] & ~dec[i] & (pend[i] == PEND_MAX);
      pend_nz[i]  = (pend[i] != '0);
      eligible[i] = pend_nz[i] & bus.req_en[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating pending counts and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ovf <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!bus.req_en[i]) begin
          pend[i] <= '0;
        end else if (inc[i] && !dec[i] && (pend[i] != PEND_MAX)) begin
          pend[i] <= pend[i] + PEND_W'(1);
        end else if (dec[i] && !inc[i] && (pend[i] != '0)) begin
          pend[i] <= pend[i] - PEND_W'(1);
        end
      end
      // A fresh overflow beats a simultaneous clear.
      ovf <= (ovf & ~{N_REQ{bus.clr_ovf}}) | new_ovf;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan from ptr+1 upward. Walking far-to-near lets the
  // nearest eligible requester overwrite any farther one.
  // ---------------------------------------------------------------------------
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (eligible[idx]) begin
        winner   = GW'(idx);
        any_elig = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_elig) state_nxt = FIRE;
      FIRE:    state_nxt = GAP;
      GAP:     if (gap_cnt == '0) state_nxt = any_elig ? FIRE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      ptr       <= PTR_RST;
      win_q     <= '0;
      gap_cnt   <= '0;
      impulse_q <= 1'b0;
      grant_q   <= '0;
    end else begin
      state     <= state_nxt;
      // Outputs are registered copies of the state about to be entered, so
      // they line up exactly with the FIRE cycle.
      impulse_q <= (state_nxt == FIRE);
      grant_q   <= (state_nxt == FIRE) ? winner : '0;
      if (state_nxt == FIRE) begin
        win_q <= winner;
      end
      if (state == FIRE) begin
        ptr     <= win_q;
        gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  assign bus.impulse  = impulse_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = (state != IDLE) | (|pend_nz);
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_impulse_sequencer.sv
// Purpose : directed self-checking bench for impulse_sequencer; dut_a uses the
//           default parameters, dut_b uses MIN_GAP=400, PEND_W=2.
// Latency : impulse timestamps are recorded by edge count and compared to
//           hand-computed values.
// Backpressure : n/a.
module tb_impulse_sequencer;

  localparam int N = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  impulse_sequencer_if #(.N_REQ(N)) bus_a ();
  impulse_sequencer_if #(.N_REQ(N)) bus_b ();

  impulse_sequencer #(
    .N_REQ(N), .DEBOUNCE_CYCLES(16), .MIN_GAP(4), .PEND_W(3)
  ) dut_a (
    .clk (clk),
    .nrst(nrst),
    .bus (bus_a)
  );

  impulse_sequencer #(
    .N_REQ(N), .DEBOUNCE_CYCLES(16), .MIN_GAP(400), .PEND_W(2)
  ) dut_b (
    .clk (clk),
    .nrst(nrst),
    .bus (bus_b)
  );

  // impulse recorders
  int   ia_cyc[$];
  int   ia_gid[$];
  int   ib_cyc[$];
  int   ib_gid[$];
  int   dbl_a  = 0;
  int   dbl_b  = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always @(negedge clk) begin
    if (bus_a.impulse) begin
      ia_cyc.push_back(cyc);
      ia_gid.push_back(int'(bus_a.grant_id));
      if (prev_a) dbl_a <= dbl_a + 1;
    end
    if (bus_b.impulse) begin
      ib_cyc.push_back(cyc);
      ib_gid.push_back(int'(bus_b.grant_id));
      if (prev_b) dbl_b <= dbl_b + 1;
    end
    prev_a <= bus_a.impulse;
    prev_b <= bus_b.impulse;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick(2);
    nrst = 1'b1;
    tick(1);
  endtask

  task automatic clear_logs();
    ia_cyc.delete();
    ia_gid.delete();
    ib_cyc.delete();
    ib_gid.delete();
  endtask

  int e0;
  int s0;

  initial begin
    bus_a.req_raw = '0;
    bus_a.req_en  = '1;
    bus_a.clr_ovf = 1'b0;
    bus_b.req_raw = '0;
    bus_b.req_en  = '1;
    bus_b.clr_ovf = 1'b0;

    // ---------------- reset values ----------------
    nrst = 1'b0;
    tick(3);
    check("rst_impulse",  int'(bus_a.impulse),  0);
    check("rst_grant",    int'(bus_a.grant_id), 0);
    check("rst_busy",     int'(bus_a.busy),     0);
    check("rst_overflow", int'(bus_a.overflow), 0);
    check("rst_b_busy",   int'(bus_b.busy),     0);
    nrst = 1'b1;
    tick(2);

    // ---------------- single press ----------------
    clear_logs();
    bus_a.req_raw[0] = 1'b1;
    e0 = cyc + 1;
    tick(100);
    bus_a.req_raw[0] = 1'b0;
    tick(40);
    check("single_count", ia_cyc.size(), 1);
    check("single_lat",   (ia_cyc.size() > 0) ? ia_cyc[0] - e0 : -1, 18);
    check("single_gid",   (ia_gid.size() > 0) ? ia_gid[0] : -1, 0);
    check("single_busy",  int'(bus_a.busy), 0);

    // ---------------- bounce rejection ----------------
    clear_logs();
    bus_a.req_raw[1] = 1'b1; tick(15);
    bus_a.req_raw[1] = 1'b0; tick(3);
    bus_a.req_raw[1] = 1'b1; tick(15);
    bus_a.req_raw[1] = 1'b0; tick(30);
    check("bounce_pend",  int'(dut_a.pend[1]), 0);
    check("bounce_count", ia_cyc.size(), 0);
    bus_a.req_raw[1] = 1'b1; tick(16);
    bus_a.req_raw[1] = 1'b0; tick(40);
    check("clean16_count", ia_cyc.size(), 1);
    check("clean16_gid",   (ia_gid.size() > 0) ? ia_gid[0] : -1, 1);

    // ---------------- simultaneous press, twice ----------------
    do_reset();
    for (int round = 0; round < 2; round++) begin
      clear_logs();
      bus_a.req_raw = 4'b0101;
      e0 = cyc + 1;
      tick(40);
      bus_a.req_raw = '0;
      tick(40);
      check("simul_count", ia_cyc.size(), 2);
      check("simul_first_lat", (ia_cyc.size() > 0) ? ia_cyc[0] - e0 : -1, 18);
      check("simul_gid0", (ia_gid.size() > 0) ? ia_gid[0] : -1, 0);
      check("simul_gid1", (ia_gid.size() > 1) ? ia_gid[1] : -1, 2);
      check("simul_space", (ia_cyc.size() > 1) ? ia_cyc[1] - ia_cyc[0] : -1, 5);
    end

    // ---------------- reset during GAP ----------------
    do_reset();
    clear_logs();
    bus_a.req_raw = 4'b0111;
    e0 = cyc + 1;
    tick(20);                       // cycle after edge e0+19: first GAP cycle
    check("rgap_pre_count", ia_cyc.size(), 1);
    check("rgap_pre_pend",  int'(dut_a.pend[1]) + int'(dut_a.pend[2]), 2);
    nrst = 1'b0;
    bus_a.req_raw = '0;
    tick(1);
    check("rgap_impulse",  int'(bus_a.impulse),  0);
    check("rgap_grant",    int'(bus_a.grant_id), 0);
    check("rgap_busy",     int'(bus_a.busy),     0);
    check("rgap_overflow", int'(bus_a.overflow), 0);
    nrst = 1'b1;
    tick(100);
    check("rgap_post_count", ia_cyc.size(), 1);

    // ---------------- disable (dut_b, long gap) ----------------
    do_reset();
    clear_logs();
    for (int p = 0; p < 3; p++) begin
      bus_b.req_raw[1] = 1'b1; tick(40);
      bus_b.req_raw[1] = 1'b0; tick(40);
    end
    check("dis_pend_before", int'(dut_b.pend[1]), 2);
    check("dis_count_before", ib_cyc.size(), 1);
    bus_b.req_en[1] = 1'b0;
    tick(1);
    check("dis_pend_after", int'(dut_b.pend[1]), 0);
    tick(400);
    check("dis_no_grant", ib_cyc.size(), 1);
    check("dis_busy", int'(bus_b.busy), 0);
    bus_b.req_en[1] = 1'b1;
    tick(50);
    check("reen_no_grant", ib_cyc.size(), 1);

    // ---------------- saturation (dut_b, PEND_W=2) ----------------
    do_reset();
    clear_logs();
    s0 = cyc;
    for (int p = 0; p < 5; p++) begin
      bus_b.req_raw[3] = 1'b1; tick(40);
      if (p == 3) check("sat_no_ovf_yet", int'(bus_b.overflow), 0);
      if (p == 4) begin
        check("sat_pend", int'(dut_b.pend[3]), 3);
        check("sat_ovf",  int'(bus_b.overflow), 8);
      end
      bus_b.req_raw[3] = 1'b0; tick(40);
    end
    bus_b.clr_ovf = 1'b1;
    tick(1);
    bus_b.clr_ovf = 1'b0;
    check("clr_ovf", int'(bus_b.overflow), 0);
    tick(1300);
    check("sat_count", ib_cyc.size(), 4);
    check("sat_first", (ib_cyc.size() > 0) ? ib_cyc[0] - s0 : -1, 19);
    for (int k = 1; k < 4; k++) begin
      check("sat_space", (ib_cyc.size() > k) ? ib_cyc[k] - ib_cyc[k-1] : -1, 401);
      check("sat_gid",   (ib_gid.size() > k) ? ib_gid[k] : -1, 3);
    end
    check("sat_busy", int'(bus_b.busy), 0);

    // ---------------- pulse width ----------------
    check("no_double_a", dbl_a, 0);
    check("no_double_b", dbl_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/impulse_sequencer.md
# impulse_sequencer

Front-end controller for the 8-bit LED event counter. It turns up to N_REQ raw, bouncy push-button inputs into clean single-cycle `impulse` pulses for the counter's increment enable. Each requester gets its own synchronizer, debouncer and saturating pending-event count. A round-robin arbiter then issues the pulses one at a time, spaced by a programmable minimum gap. It sits between the board buttons and the counter, and the counter consumes `impulse` directly.

## Interface
- N_REQ, 4: number of requesters; 2..8.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples needed to accept a level change; ≥2.
- MIN_GAP, 4: idle cycles forced after each impulse; ≥1.
- PEND_W, 3: width of each per-requester pending count; saturates at 2^PEND_W-1.
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- req_raw  in  N_REQ  asynchronous button levels, active-high.
- req_en  in  N_REQ  per-requester enable, synchronous to clk.
- clr_ovf  in  1  one-cycle pulse; clears all `overflow` bits.
- impulse  out  1  one-cycle increment pulse to the counter.
- grant_id  out  $clog2(N_REQ)  index served; valid only while `impulse`=1.
- busy  out  1  FSM not IDLE, or any pending count nonzero.
- overflow  out  N_REQ  sticky flag: an event was lost to saturation.

## Operation
- **Synchronizer:** 2-flop synchronizer per `req_raw` bit.
- **Debouncer:**
  - Per-requester counter increments each cycle the synchronized value differs from `stable[i]`.
  - The counter resets to 0 on any cycle where they match.
  - When the DEBOUNCE_CYCLES-th consecutive differing sample is seen, `stable[i]` flips and the counter clears.
- **Event capture:**
  - A 0→1 transition of `stable[i]` with `req_en[i]`=1 increments `pend[i]` at the same clock edge at which `stable[i]` flips.
  - Falling transitions are ignored.
- **Saturation:** an increment while `pend[i]` is at its maximum leaves it at the maximum and sets `overflow[i]`.
- **Simultaneous increment and grant decrement** on the same requester in the same cycle: `pend[i]` is unchanged.
- **Disabled requester:** while `req_en[i]`=0, `pend[i]` is forced to 0 and requester i is not eligible. Its debouncer keeps running.
- **clr_ovf vs. new overflow:** if `clr_ovf` and a new overflow event occur in the same cycle, the new overflow wins and the bit stays 1.
- **FSM states:** IDLE, FIRE, GAP.
  - IDLE: if any eligible `pend` is nonzero, latch the round-robin winner and go to FIRE; otherwise stay.
  - FIRE (exactly 1 cycle):
    - `impulse`=1 and `grant_id`=winner.
    - `pend[winner]` decrements at the end of the cycle.
    - The round-robin pointer updates to the winner.
    - Go to GAP.
  - GAP (MIN_GAP cycles, internal counter): on the last GAP cycle, if any eligible `pend` is nonzero, go directly to FIRE with the new winner; else go to IDLE.
- **Round-robin:**
  - Search starts at pointer+1, modulo N_REQ.
  - Pointer reset value is N_REQ-1, so requester 0 has first priority.
- **Outputs:** `impulse` and `grant_id` are registered outputs decoded from the state register. `grant_id` reads 0 when `impulse`=0.

## Timing
- **Reset values** (with `nrst`=0 at a clock edge):
  - `impulse`=0, `grant_id`=0, `busy`=0, `overflow`=0.
  - All `pend`=0, all `stable`=0, all debounce counters=0, synchronizers=0.
  - FSM=IDLE, RR pointer=N_REQ-1.
- **Reset mid-operation:** all pending events are discarded and any GAP is abandoned. No impulse is asserted in the cycle following reset release.
- **Press latency:**
  - Let E0 be the edge that first samples `req_raw[i]`=1 (held steady).
  - `pend[i]` becomes 1 at edge E0+1+DEBOUNCE_CYCLES.
  - `impulse` is high in the cycle after edge E0+2+DEBOUNCE_CYCLES (E0+18 for defaults) if the FSM was IDLE.
- **Impulse spacing:** consecutive impulses are exactly MIN_GAP+1 cycles apart when work is continuously pending, and never closer.
- **Pulse width:** `impulse` is never asserted for 2 consecutive cycles.
- **busy:** `busy` deasserts the cycle after the FSM returns to IDLE with all `pend`=0.

## Test plan
- **Single press, defaults:** raw[0] high for 100 cycles → exactly one impulse with `grant_id`=0, 18 cycles after first sampling edge; `busy` returns to 0.
- **Bounce rejection:** raw[1] high for 15 cycles, low 3, high 15, then low → no impulse, `pend[1]` stays 0. A 16-cycle high pulse afterwards → exactly one impulse.
- **Simultaneous press:** raw[0] and raw[2] rise on the same edge → impulses with `grant_id` 0 then 2, 5 cycles apart. A further simultaneous press → order 0,2 again (pointer at 2 wraps past 3 to 0).
- **Saturation:**
  - Setup: MIN_GAP=400, PEND_W=2; 5 clean presses on raw[3], each 40 high / 40 low.
  - Required response: pend saturates at 3 and `overflow[3]`=1.
  - After `clr_ovf`: `overflow`=0.
- **Disable:** two pending events on requester 1, drop `req_en[1]` → `pend[1]`=0 next cycle and no further grants to 1. Re-enable with no new press → no impulse.
- **Reset mid-GAP:** assert `nrst`=0 for 1 cycle during GAP with 2 events pending → all outputs at reset values and no impulse thereafter without new presses.
